// File: rtl/tsp_pkg.sv
// Shared types and arithmetic helpers for the travelling-salesman demo core.
// Holds the Manhattan distance, the 2-opt delta and the xorshift32 step.
package tsp_pkg;

   localparam int N_CITY  = 64;
   localparam int COORD_W = 10;
   localparam int IDX_W   = 6;

   typedef logic [COORD_W-1:0]        coord_t;
   typedef logic [IDX_W-1:0]          idx_t;
   typedef logic [COORD_W:0]          dist_t;
   typedef logic signed [COORD_W+3:0] delta_t;

   typedef enum logic [1:0] {
      GEN  = 2'd0,
      PICK = 2'd1,
      EVAL = 2'd2,
      REV  = 2'd3
   } state_t;

   function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   function automatic dist_t manhattan(input coord_t xu, input coord_t yu,
                                       input coord_t xv, input coord_t yv);
      coord_t dx;
      coord_t dy;
      dx = (xu >= xv) ? (xu - xv) : (xv - xu);
      dy = (yu >= yv) ? (yu - yv) : (yv - yu);
      return {1'b0, dx} + {1'b0, dy};
   endfunction

   // Gain of reversing the segment A..B between neighbours P and Q; negative means shorter.
   function automatic delta_t calc_delta(input coord_t xp, input coord_t yp,
                                         input coord_t xa, input coord_t ya,
                                         input coord_t xb, input coord_t yb,
                                         input coord_t xq, input coord_t yq);
      dist_t d_pb;
      dist_t d_aq;
      dist_t d_pa;
      dist_t d_bq;
      d_pb = manhattan(xp, yp, xb, yb);
      d_aq = manhattan(xa, ya, xq, yq);
      d_pa = manhattan(xp, yp, xa, ya);
      d_bq = manhattan(xb, yb, xq, yq);
      return $signed({3'b000, d_pb}) + $signed({3'b000, d_aq})
           - $signed({3'b000, d_pa}) - $signed({3'b000, d_bq});
   endfunction

endpackage

// File: rtl/tsp_solver_if.sv
// Observation bundle of the solver: city coordinates and the current tour,
// all zero-extended to 32 bits per entry.
interface tsp_solver_if;
   import tsp_pkg::*;

   logic [31:0] xs   [N_CITY];
   logic [31:0] ys   [N_CITY];
   logic [31:0] path [N_CITY];

   modport master (output xs, ys, path);
   modport slave  (input  xs, ys, path);

endinterface

// File: rtl/tsp_xorshift32.sv
// 32-bit xorshift pseudo-random source; the current value is visible on out
// and advances by one step on each cycle where step is high.
module tsp_xorshift32
   import tsp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] out
);

   logic [31:0] state_r;

   // Generator state: reload seed on reset, advance on each consumed draw.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= seed;
      end else if (step) begin
         state_r <= xorshift32_next(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign out = state_r;

endmodule

// File: rtl/tsp_solver.sv
// Travelling-salesman demo core: builds 64 pseudo-random cities after reset,
// then shortens a closed tour forever with randomized 2-opt segment reversals.
module tsp_solver
   import tsp_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h2463_534A
) (
   input  logic         clk,
   input  logic         rst,
   tsp_solver_if.master bus
);

   state_t      state_r;
   state_t      state_s;

   coord_t      xs_r   [N_CITY];
   coord_t      ys_r   [N_CITY];
   idx_t        path_r [N_CITY];

   idx_t        gen_idx_r;
   logic        gen_phase_r;
   idx_t        lo_r;
   idx_t        hi_r;

   logic [31:0] rnd_s;
   logic        step_s;
   logic        unused_rnd_s;

   idx_t        a_s;
   idx_t        b_s;
   idx_t        pick_lo_s;
   idx_t        pick_hi_s;
   logic        skip_s;

   idx_t        lo_m1_s;
   idx_t        hi_p1_s;
   idx_t        span_s;
   idx_t        p_s;
   idx_t        c_a_s;
   idx_t        c_b_s;
   idx_t        q_s;
   delta_t      delta_s;
   logic        rev_last_s;

   tsp_xorshift32 u_prng (
      .clk  (clk),
      .rst  (rst),
      .step (step_s),
      .seed (SEED),
      .out  (rnd_s)
   );

   assign unused_rnd_s = ^rnd_s[31:14];

   // Decode a PICK draw into an ordered index pair and reject degenerate moves.
   always_comb begin
      a_s = rnd_s[5:0];
      b_s = rnd_s[13:8];
      if (a_s <= b_s) begin
         pick_lo_s = a_s;
         pick_hi_s = b_s;
      end else begin
         pick_lo_s = b_s;
         pick_hi_s = a_s;
      end
      skip_s = (pick_lo_s == pick_hi_s) || (pick_lo_s == 6'd0)
            || ((pick_lo_s == 6'd1) && (pick_hi_s == 6'd63));
   end

   // Look up the four tour neighbours of the candidate segment and its length delta.
   always_comb begin
      lo_m1_s    = lo_r - 6'd1;
      hi_p1_s    = hi_r + 6'd1;
      span_s     = hi_r - lo_r;
      p_s        = path_r[lo_m1_s];
      c_a_s      = path_r[lo_r];
      c_b_s      = path_r[hi_r];
      q_s        = path_r[hi_p1_s];
      delta_s    = calc_delta(xs_r[p_s],   ys_r[p_s],
                              xs_r[c_a_s], ys_r[c_a_s],
                              xs_r[c_b_s], ys_r[c_b_s],
                              xs_r[q_s],   ys_r[q_s]);
      rev_last_s = (span_s <= 6'd2);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= GEN;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and PRNG consumption.
   always_comb begin
      state_s = state_r;
      step_s  = 1'b0;
      case (state_r)
         GEN: begin
            step_s = 1'b1;
            if (gen_phase_r && (gen_idx_r == 6'd63)) begin
               state_s = PICK;
            end else begin
               state_s = GEN;
            end
         end
         PICK: begin
            step_s = 1'b1;
            if (skip_s) begin
               state_s = PICK;
            end else begin
               state_s = EVAL;
            end
         end
         EVAL: begin
            if (delta_s[COORD_W+3]) begin
               state_s = REV;
            end else begin
               state_s = PICK;
            end
         end
         REV: begin
            if (rev_last_s) begin
               state_s = PICK;
            end else begin
               state_s = REV;
            end
         end
         default: begin
            state_s = GEN;
         end
      endcase
   end

   // Coordinate generation, move capture and the in-place segment reversal.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N_CITY; k++) begin
            xs_r[k]   <= '0;
            ys_r[k]   <= '0;
            path_r[k] <= idx_t'(k);
         end
         gen_idx_r   <= 6'd0;
         gen_phase_r <= 1'b0;
         lo_r        <= 6'd0;
         hi_r        <= 6'd0;
      end else begin
         case (state_r)
            GEN: begin
               if (!gen_phase_r) begin
                  xs_r[gen_idx_r] <= rnd_s[COORD_W-1:0];
               end else begin
                  ys_r[gen_idx_r] <= rnd_s[COORD_W-1:0];
                  gen_idx_r       <= gen_idx_r + 6'd1;
               end
               gen_phase_r <= ~gen_phase_r;
            end
            PICK: begin
               lo_r <= pick_lo_s;
               hi_r <= pick_hi_s;
            end
            REV: begin
               // A single swap per edge keeps path a permutation mid-reversal.
               path_r[lo_r] <= path_r[hi_r];
               path_r[hi_r] <= path_r[lo_r];
               lo_r         <= lo_r + 6'd1;
               hi_r         <= hi_r - 6'd1;
            end
            default: begin
               lo_r <= lo_r;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_CITY; g++) begin : g_out
      assign bus.xs[g]   = {{(32-COORD_W){1'b0}}, xs_r[g]};
      assign bus.ys[g]   = {{(32-COORD_W){1'b0}}, ys_r[g]};
      assign bus.path[g] = {{(32-IDX_W){1'b0}}, path_r[g]};
   end

endmodule

// File: tb/tb_tsp_solver.sv
// Self-checking bench for tsp_solver: coordinate generation against an
// xorshift32 model, tour permutation, monotonic length, reset and delta checks.
module tb_tsp_solver;
   import tsp_pkg::*;

   localparam logic [31:0] SEED = 32'h2463_534A;

   logic clk;
   logic rst;

   tsp_solver_if bus ();

   tsp_solver #(.SEED(SEED)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_x [$];
   logic [31:0] exp_y [$];
   logic [31:0] gold_x [N_CITY];
   logic [31:0] gold_y [N_CITY];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_next(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   function automatic int absi(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int tour_len_dut();
      int s;
      s = 0;
      for (int k = 0; k < N_CITY; k++) begin
         int u;
         int v;
         u = int'(bus.path[k][5:0]);
         v = int'(bus.path[(k + 1) % N_CITY][5:0]);
         s += absi(int'(bus.xs[u]) - int'(bus.xs[v])) + absi(int'(bus.ys[u]) - int'(bus.ys[v]));
      end
      return s;
   endfunction

   function automatic int ident_len_gold();
      int s;
      s = 0;
      for (int k = 0; k < N_CITY; k++) begin
         int v;
         v = (k + 1) % N_CITY;
         s += absi(int'(gold_x[k]) - int'(gold_x[v])) + absi(int'(gold_y[k]) - int'(gold_y[v]));
      end
      return s;
   endfunction

   // Scoreboard producer: expected coordinates for one generation pass.
   task automatic push_expected();
      logic [31:0] x;
      x = SEED;
      for (int i = 0; i < N_CITY; i++) begin
         gold_x[i] = {22'd0, x[9:0]};
         exp_x.push_back(gold_x[i]);
         x = model_next(x);
         gold_y[i] = {22'd0, x[9:0]};
         exp_y.push_back(gold_y[i]);
         x = model_next(x);
      end
   endtask

   // Scoreboard consumer: wait out generation, then pop and compare every city.
   task automatic check_gen(input string tag);
      logic [31:0] ex;
      logic [31:0] ey;
      int          bad_range;
      repeat (130) @(posedge clk);
      @(negedge clk);
      bad_range = 0;
      for (int k = 0; k < N_CITY; k++) begin
         ex = exp_x.pop_front();
         ey = exp_y.pop_front();
         n_vec++;
         if (bus.xs[k] !== ex) begin
            n_err++;
            $display("FAIL %s_x[%0d]: got %0d expected %0d", tag, k, bus.xs[k], ex);
         end
         n_vec++;
         if (bus.ys[k] !== ey) begin
            n_err++;
            $display("FAIL %s_y[%0d]: got %0d expected %0d", tag, k, bus.ys[k], ey);
         end
         if (bus.xs[k] >= 32'd1024 || bus.ys[k] >= 32'd1024) bad_range++;
      end
      n_vec++;
      if (bad_range !== 0) begin
         n_err++;
         $display("FAIL %s_range: got %0d out-of-range cities expected 0", tag, bad_range);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < N_CITY; k++) begin
         n_vec++;
         if (bus.xs[k] !== 32'd0 || bus.ys[k] !== 32'd0 || bus.path[k] !== 32'(k)) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got x=%0d y=%0d path=%0d expected x=0 y=0 path=%0d",
                     k, bus.xs[k], bus.ys[k], bus.path[k], k);
         end
      end
      push_expected();
      rst = 1'b1;
      check_gen("gen");
   endtask

   task automatic test_mid_rev_reset();
      logic found;
      int   bad;
      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         @(negedge clk);
         if (dut.state_r == REV) found = 1'b1;
      end
      n_vec++;
      if (!found) begin
         n_err++;
         $display("FAIL rev_reached: got no REV state within 5000 cycles expected REV");
      end else begin
         rst = 1'b0;
         #1;
         bad = 0;
         for (int k = 0; k < N_CITY; k++) begin
            if (bus.path[k] !== 32'(k) || bus.xs[k] !== 32'd0 || bus.ys[k] !== 32'd0) bad++;
         end
         n_vec++;
         if (bad !== 0) begin
            n_err++;
            $display("FAIL async_reset: got %0d non-reset cities expected 0", bad);
         end
         @(negedge clk);
         push_expected();
         rst = 1'b1;
         check_gen("regen");
      end
   endtask

   task automatic test_permutation();
      logic [63:0] mask;
      int          oor;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         mask = '0;
         oor  = 0;
         for (int k = 0; k < N_CITY; k++) begin
            if (bus.path[k] >= 32'd64) oor++;
            mask[bus.path[k][5:0]] = 1'b1;
         end
         n_vec++;
         if (mask !== {64{1'b1}} || oor !== 0) begin
            n_err++;
            $display("FAIL permutation@%0d: got mask=%h out_of_range=%0d expected all cities once",
                     c, mask, oor);
         end
      end
   endtask

   task automatic test_delta_unit();
      int d;
      // Square crossed as 0,2,1,3: P=c0 A=c2 B=c1 Q=c3.
      d = int'(calc_delta(10'd0, 10'd0, 10'd10, 10'd10, 10'd0, 10'd10, 10'd10, 10'd0));
      n_vec++;
      if (d !== -20) begin
         n_err++;
         $display("FAIL delta_crossed: got %0d expected -20", d);
      end
      d = int'(calc_delta(10'd0, 10'd0, 10'd0, 10'd10, 10'd10, 10'd10, 10'd10, 10'd0));
      n_vec++;
      if (d !== 20) begin
         n_err++;
         $display("FAIL delta_uncrossed: got %0d expected 20", d);
      end
      d = int'(calc_delta(10'd0, 10'd0, 10'd0, 10'd0, 10'd1023, 10'd1023, 10'd1023, 10'd1023));
      n_vec++;
      if (d !== 4092) begin
         n_err++;
         $display("FAIL delta_max_pos: got %0d expected 4092", d);
      end
      d = int'(calc_delta(10'd0, 10'd0, 10'd1023, 10'd1023, 10'd0, 10'd0, 10'd1023, 10'd1023));
      n_vec++;
      if (d !== -4092) begin
         n_err++;
         $display("FAIL delta_max_neg: got %0d expected -4092", d);
      end
   endtask

   task automatic test_monotonic();
      int prev;
      int cur;
      int ident;
      ident = ident_len_gold();
      @(negedge clk);
      prev = tour_len_dut();
      for (int s = 1; s <= 300; s++) begin
         repeat (100) @(posedge clk);
         @(negedge clk);
         cur = tour_len_dut();
         n_vec++;
         if (cur > prev) begin
            n_err++;
            $display("FAIL length_monotonic@%0d: got %0d expected <= %0d", s, cur, prev);
         end
         if (s == 100) begin
            n_vec++;
            if (cur >= ident) begin
               n_err++;
               $display("FAIL length_improved: got %0d expected < identity %0d", cur, ident);
            end
         end
         prev = cur;
      end
   endtask

   task automatic test_stability();
      int bad;
      bad = 0;
      for (int k = 0; k < N_CITY; k++) begin
         if (bus.xs[k] !== gold_x[k] || bus.ys[k] !== gold_y[k]) bad++;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL coord_stability: got %0d changed cities expected 0", bad);
      end
   endtask

   initial begin
      rst = 1'b0;
      test_reset();
      test_mid_rev_reset();
      test_permutation();
      test_delta_unit();
      test_monotonic();
      test_stability();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
